// File: rtl/scic_io_pkg.sv
// Shared types and constants for the switch conditioning path.
`timescale 1ns/1ps
package scic_io_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch vector handshake between the debouncer (slave) and its consumer (master).
`timescale 1ns/1ps
interface switch_debouncer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] switches_raw;
    logic [WIDTH-1:0] switches;
    logic             sw_valid;
    logic             sw_ack;
    logic             sw_overrun;

    modport master (
        output switches_raw,
        output sw_ack,
        input  switches,
        input  sw_valid,
        input  sw_overrun
    );

    modport slave (
        input  switches_raw,
        input  sw_ack,
        output switches,
        output sw_valid,
        output sw_overrun
    );
endinterface

// File: rtl/sync_2ff.sv
// Per-bit two-flop synchronizer for asynchronous level inputs.
`timescale 1ns/1ps
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] out_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            out_q  <= '0;
        end else begin
            meta_q <= d;
            out_q  <= meta_q;
        end
    end

    assign q = out_q;
endmodule

// File: rtl/switch_debouncer.sv
// Whole-vector switch debouncer with a sticky valid/ack handshake and overrun flag.
`timescale 1ns/1ps
module switch_debouncer
    import scic_io_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic                clock,
    input logic                reset,
    switch_debouncer_if.slave  sw_if
);
    localparam int unsigned     CntW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q;
    deb_state_e       state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sw_q, sw_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             update;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (sw_if.switches_raw),
        .q     (sync_q)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        update  = 1'b0;
        unique case (state_q)
            STABLE: begin
                if (sync_q != sw_q) begin
                    state_d = SETTLING;
                    cand_d  = sync_q;
                    cnt_d   = '0;
                end
            end
            SETTLING: begin
                if (sync_q == sw_q) begin
                    state_d = STABLE;
                end else if (sync_q != cand_q) begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end else if (cnt_q == CntLast) begin
                    update  = 1'b1;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end

    // An ack on the same edge as an update consumes the old value only.
    always_comb begin
        sw_d    = update ? cand_q : sw_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (update) begin
            valid_d = 1'b1;
        end else if (sw_if.sw_ack && valid_q) begin
            valid_d = 1'b0;
        end
        if (sw_if.sw_ack && valid_q) begin
            ovr_d = 1'b0;
        end else if (update && valid_q) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            sw_q    <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sw_if.switches   = sw_q;
    assign sw_if.sw_valid   = valid_q;
    assign sw_if.sw_overrun = ovr_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer: a driver queues expected updates, a monitor checks them.
`timescale 1ns/1ps
module tb_switch_debouncer;
    import scic_io_pkg::*;

    localparam int unsigned W  = 4;
    localparam int unsigned DC = 4;

    typedef struct {
        logic [W-1:0] val;
        int unsigned  at;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned edge_n = 0;
    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;
    exp_t        exp_q[$];
    logic [W-1:0] prev_sw = '0;

    switch_debouncer_if #(.WIDTH(W)) sw_if ();

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw_if (sw_if)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Every change of the debounced vector outside reset must match the head of the queue.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            prev_sw <= sw_if.switches;
        end else if (sw_if.switches !== prev_sw) begin
            prev_sw <= sw_if.switches;
            if (exp_q.size() == 0) begin
                check("unexpected_update", 32'(sw_if.switches), 32'(prev_sw));
            end else begin
                e = exp_q.pop_front();
                check("update_value", 32'(sw_if.switches), 32'(e.val));
                check("update_edge", edge_n, e.at);
                check("update_valid", 32'(sw_if.sw_valid), 32'd1);
            end
        end
    end

    task automatic neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge: the value is steady before the next edge, so it lands DC+2 edges later.
    task automatic drive(input logic [W-1:0] v, input bit expect_upd);
        sw_if.switches_raw = v;
        if (expect_upd) exp_q.push_back('{v, edge_n + 1 + DC + 2});
    endtask

    task automatic pulse_ack();
        sw_if.sw_ack = 1'b1;
        neg(1);
        sw_if.sw_ack = 1'b0;
    endtask

    task automatic check_flags(input string name, input logic valid, input logic ovr);
        check({name, "_valid"}, 32'(sw_if.sw_valid), 32'(valid));
        check({name, "_overrun"}, 32'(sw_if.sw_overrun), 32'(ovr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        sw_if.switches_raw = '0;
        sw_if.sw_ack       = 1'b0;
        reset              = 1'b1;
        #7 reset = 1'b0;
        #1;
        check("reset_switches", 32'(sw_if.switches), 32'h0);
        check_flags("reset", 1'b0, 1'b0);

        // 0101 applied at 20 ns, steady before the 25 ns edge, lands on the 85 ns edge (edge 9).
        neg(2);
        sw_if.switches_raw = 4'b0101;
        exp_q.push_back('{4'b0101, 9});
        neg(6);
        check("pre_update_switches", 32'(sw_if.switches), 32'h0);
        check("pre_update_valid", 32'(sw_if.sw_valid), 32'd0);
        neg(1);
        check("first_update_switches", 32'(sw_if.switches), 32'h5);
        check_flags("first_update", 1'b1, 1'b0);
        pulse_ack();
        check_flags("first_ack", 1'b0, 1'b0);

        // Two-cycle glitch must be rejected.
        drive(4'b0111, 1'b0);
        neg(2);
        drive(4'b0101, 1'b0);
        neg(10);
        check("glitch_switches", 32'(sw_if.switches), 32'h5);
        check("glitch_valid", 32'(sw_if.sw_valid), 32'd0);

        // Bounce 1000/0000/1000 then held: one update, timed from the last bounce.
        drive(4'b1000, 1'b0);
        neg(1);
        drive(4'b0000, 1'b0);
        neg(1);
        drive(4'b1000, 1'b1);
        neg(DC + 3);
        check("bounce_switches", 32'(sw_if.switches), 32'h8);
        check_flags("bounce", 1'b1, 1'b0);
        pulse_ack();

        // Two updates without ack: overrun, newest value kept.
        drive(4'b0001, 1'b1);
        neg(8);
        drive(4'b0010, 1'b1);
        neg(8);
        check("overrun_switches", 32'(sw_if.switches), 32'h2);
        check_flags("overrun", 1'b1, 1'b1);
        pulse_ack();
        check_flags("overrun_ack", 1'b0, 1'b0);

        // Ack on the very edge of an update: valid stays, overrun clears.
        drive(4'b0011, 1'b1);
        neg(8);
        check_flags("pre_coincide_a", 1'b1, 1'b0);
        drive(4'b0110, 1'b1);
        neg(8);
        check_flags("pre_coincide_b", 1'b1, 1'b1);
        drive(4'b0100, 1'b1);
        neg(DC + 2);
        check("pre_coincide_switches", 32'(sw_if.switches), 32'h6);
        pulse_ack();
        check("coincide_switches", 32'(sw_if.switches), 32'h4);
        check_flags("coincide", 1'b1, 1'b0);
        pulse_ack();
        check_flags("coincide_ack", 1'b0, 1'b0);
        pulse_ack();
        check_flags("idle_ack", 1'b0, 1'b0);

        // Reset two cycles into SETTLING toward 1111 abandons the candidate.
        drive(4'b1111, 1'b0);
        neg(4);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_switches", 32'(sw_if.switches), 32'h0);
        check_flags("reset_mid", 1'b0, 1'b0);
        neg(2);
        #2 reset = 1'b0;
        exp_q.push_back('{4'b1111, edge_n + 1 + DC + 2});
        #1;
        check("post_reset_switches", 32'(sw_if.switches), 32'h0);
        neg(DC + 2);
        check("post_reset_early_switches", 32'(sw_if.switches), 32'h0);
        neg(1);
        check("post_reset_switches_late", 32'(sw_if.switches), 32'hF);
        check_flags("post_reset", 1'b1, 1'b0);

        neg(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 4: number of switch bits conditioned.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before acceptance; legal range 1..65535.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-high, with ports named clock and reset.
REQ-004 clock  input  1  system clock, 100 MHz, rising-edge active.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 switches_raw  input  WIDTH  board switches; asynchronous and bouncing.
REQ-007 switches  output  WIDTH  debounced switch vector; drives the system switches port.
REQ-008 sw_valid  output  1  new debounced value available; sticky until acknowledged.
REQ-009 sw_ack  input  1  consumer acknowledge, sampled on the rising edge of clock.
REQ-010 sw_overrun  output  1  a debounced update occurred while sw_valid was already set and not acknowledged.

Function
REQ-011 switches_raw SHALL pass through a 2-flop synchronizer per bit; the synchronized vector is sync_q.
REQ-012 The FSM SHALL have two states, STABLE and SETTLING, and SHALL debounce the whole vector as one unit, not per bit.
REQ-013 In STABLE, if sync_q differs from switches: go to SETTLING, set candidate to sync_q, clear the counter to 0.
REQ-014 In SETTLING, if sync_q equals switches: return to STABLE; switches and sw_valid are unchanged (glitch rejected).
REQ-015 In SETTLING, else if sync_q differs from candidate: set candidate to sync_q, clear the counter to 0, stay in SETTLING.
REQ-016 In SETTLING, else if counter equals DEBOUNCE_CYCLES-1: load switches from candidate, set sw_valid, return to STABLE.
REQ-017 In SETTLING, otherwise: increment the counter by 1.
REQ-018 The counter width SHALL be clog2(DEBOUNCE_CYCLES), minimum 1 bit; the counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 Latency: for an input steady before rising edge E0, switches SHALL update at edge E0+DEBOUNCE_CYCLES+2 (E0+6 at default).
REQ-020 sw_ack with sw_valid=1 and no update in the same cycle SHALL clear sw_valid and sw_overrun on that edge.
REQ-021 An update and sw_ack in the same cycle SHALL leave sw_valid=1; sw_overrun SHALL be cleared.
REQ-022 An update while sw_valid=1 and sw_ack=0 SHALL set sw_overrun; switches SHALL take the newest value.
REQ-023 sw_ack while sw_valid=0 SHALL be ignored.
REQ-024 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-025 Reset SHALL asynchronously force: switches=0, sw_valid=0, sw_overrun=0, synchronizer flops=0, candidate=0, counter=0, state=STABLE.
REQ-026 Reset asserted mid-SETTLING SHALL abandon the pending candidate; no update SHALL follow the reset release.
REQ-027 After reset release, a nonzero switches_raw SHALL be debounced as a normal change from 0.

Structure
REQ-028 The package scic_io_pkg SHALL hold the debounce state enum (STABLE, SETTLING) and the constant DEFAULT_DEBOUNCE_CYCLES=4.
REQ-029 The per-bit 2-flop synchronizer SHALL be the sub-module sync_2ff (parameter WIDTH, ports clock, reset, d, q), instantiated once.
REQ-030 The FSM, counter, candidate register and handshake logic SHALL reside in switch_debouncer.

Verification (10 ns clock, DEBOUNCE_CYCLES=4, WIDTH=4)
REQ-031 Reset at 0 ns, released at 7 ns, switches_raw=0000 -> switches=0000, sw_valid=0, sw_overrun=0 throughout.
REQ-032 switches_raw=0101 held from 20 ns -> switches=0101 and sw_valid=1 at the rising edge at 85 ns; sw_ack pulse at 95 ns -> sw_valid=0.
REQ-033 From a stable 0101, switches_raw glitches to 0111 for 2 cycles -> switches stays 0101 and sw_valid stays 0.
REQ-034 Bounce sequence 1000, 0000, 1000 at 1-cycle spacing, then 1000 held -> a single update to 1000, DEBOUNCE_CYCLES+2 edges after the last bounce is sampled.
REQ-035 Two debounced updates (0001 then 0010) with no sw_ack -> switches=0010, sw_valid=1, sw_overrun=1; sw_ack -> both flags 0; ack coinciding with an update -> sw_valid stays 1.
REQ-036 Reset asserted 2 cycles into SETTLING toward 1111, then released with switches_raw=1111 -> switches=0000 immediately, 1111 only after a full new debounce.
